// File: rtl/audio_decim_fifo.sv
// Decimating front end for the PDM mic path. It averages R = 2^DECIM_LOG2 samples (floor of the
// mean) and queues each result in a circular FIFO, with sticky overflow and peak-level monitors.
module audio_decim_fifo #(
    parameter int unsigned SAMPLE_DEPTH = 16,
    parameter int unsigned DECIM_LOG2   = 2,
    parameter int unsigned FIFO_LOG2    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_DEPTH-1:0] in_sample,
    input  logic                           rd_en,
    output logic signed [SAMPLE_DEPTH-1:0] rd_data,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           full,
    output logic [FIFO_LOG2:0]             count,
    output logic                           overflow,
    output logic [SAMPLE_DEPTH-2:0]        peak,
    input  logic                           flags_clr
);

    localparam int unsigned ACC_W = SAMPLE_DEPTH + DECIM_LOG2;
    // A zero-width phase is not legal, so pass-through mode keeps one bit pinned at 0.
    localparam int unsigned PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;

    localparam logic [PH_W-1:0]      PHASE_LAST = PH_W'((1 << DECIM_LOG2) - 1);
    localparam logic [FIFO_LOG2:0]   COUNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [SAMPLE_DEPTH-2:0] ABS_MAX = '1;

    // Decimator state
    logic signed [ACC_W-1:0]        acc;
    logic [PH_W-1:0]                phase;
    logic                           pend_valid;
    logic signed [SAMPLE_DEPTH-1:0] pend_data;

    // FIFO state
    logic [SAMPLE_DEPTH-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0]    wr_ptr;
    logic [FIFO_LOG2-1:0]    rd_ptr;

    logic signed [ACC_W-1:0]        acc_sum;
    logic signed [ACC_W-1:0]        dec_wide;
    logic signed [SAMPLE_DEPTH-1:0] dec_value;
    logic                           phase_last;
    logic                           push;
    logic                           pop;
    logic [SAMPLE_DEPTH-1:0]        neg_data;
    logic [SAMPLE_DEPTH-2:0]        wr_abs;

    always_comb begin
        acc_sum    = acc + ACC_W'(in_sample);
        dec_wide   = acc_sum >>> DECIM_LOG2;
        dec_value  = dec_wide[SAMPLE_DEPTH-1:0];
        phase_last = (phase == PHASE_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            phase      <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            pend_valid <= 1'b0;
            if (in_valid) begin
                if (phase_last) begin
                    acc        <= '0;
                    phase      <= '0;
                    pend_valid <= 1'b1;
                    pend_data  <= dec_value;
                end else begin
                    acc   <= acc_sum;
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    // Absolute value of the pending write; the most negative code saturates.
    always_comb begin
        neg_data = -pend_data;
        wr_abs   = pend_data[SAMPLE_DEPTH-2:0];
        if (pend_data[SAMPLE_DEPTH-1]) begin
            if (pend_data[SAMPLE_DEPTH-2:0] == '0) begin
                wr_abs = ABS_MAX;
            end else begin
                wr_abs = neg_data[SAMPLE_DEPTH-2:0];
            end
        end
    end

    always_comb begin
        empty = (count == '0);
        full  = (count == COUNT_FULL);
        pop   = rd_en && !empty;
        // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
        push  = pend_valid && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pend_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            peak     <= '0;
        end else if (flags_clr) begin
            overflow <= 1'b0;
            peak     <= pend_valid ? wr_abs : '0;
        end else begin
            if (pend_valid && !push) begin
                overflow <= 1'b1;
            end
            if (pend_valid && (wr_abs > peak)) begin
                peak <= wr_abs;
            end
        end
    end

endmodule

// File: tb/tb_audio_decim_fifo.sv
// Scoreboard bench for audio_decim_fifo at default parameters (R = 4, D = 16).
module tb_audio_decim_fifo;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic               rd_en;
    logic signed [15:0] rd_data;
    logic               rd_valid;
    logic               empty;
    logic               full;
    logic [4:0]         count;
    logic               overflow;
    logic [14:0]        peak;
    logic               flags_clr;

    int total;
    int bad;
    int exp_q[$];

    audio_decim_fifo #(
        .SAMPLE_DEPTH(16),
        .DECIM_LOG2  (2),
        .FIFO_LOG2   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sample(in_sample),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .peak     (peak),
        .flags_clr(flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        rd_en = 1'b0;
        flags_clr = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Drives four back-to-back strobes; model pushes the floor mean unless the FIFO is full.
    task automatic send_group(input int a, input int b, input int c, input int d, input bit model);
        int s[4];
        int e;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'(s[i]);
            tick();
        end
        in_valid = 1'b0;
        e = (a + b + c + d) >>> 2;
        if (model && exp_q.size() < 16) exp_q.push_back(e);
    endtask

    task automatic do_read(input string name);
        logic signed [15:0] e;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, rd_valid=%0b rd_data=%0d", name, rd_valid, rd_data);
        end else begin
            e = 16'(exp_q.pop_front());
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                bad++;
                $display("FAIL %s: got valid=%0b data=%0d, want valid=1 data=%0d",
                         name, rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (rd_data !== 16'sd0 || rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0 || peak !== 15'd0) begin
            bad++;
            $display("FAIL %s: got data=%0d valid=%0b count=%0d empty=%0b full=%0b ovf=%0b peak=%0d, want 0 0 0 1 0 0 0",
                     name, rd_data, rd_valid, count, empty, full, overflow, peak);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        rd_en = 1'b0;
        flags_clr = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_mean();
        send_group(100, 200, 300, 401, 1'b1);
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL mean_empty_early: got empty=%0b, want 1", empty);
        end
        tick();
        total++;
        if (empty !== 1'b0 || count !== 5'd1) begin
            bad++;
            $display("FAIL mean_empty_fall: got empty=%0b count=%0d, want 0 1", empty, count);
        end
        do_read("mean_250");
        tick();
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL mean_valid_pulse: got rd_valid=%0b, want 0", rd_valid);
        end
    endtask

    task automatic test_floor();
        send_group(-1, -1, -1, -2, 1'b1);
        tick();
        do_read("floor_neg2");
        send_group(-32768, -32768, -32768, -32768, 1'b1);
        tick();
        do_read("min_code");
        total++;
        if (peak !== 15'd32767) begin
            bad++;
            $display("FAIL peak_saturate: got peak=%0d, want 32767", peak);
        end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            send_group(k, k, k, k, 1'b1);
            tick();
            if (k == 16) begin
                total++;
                if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_16: got full=%0b count=%0d ovf=%0b, want 1 16 0",
                             full, count, overflow);
                end
            end
        end
        total++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("FAIL overflow_17: got ovf=%0b count=%0d, want 1 16", overflow, count);
        end
        for (int k = 0; k < 16; k++) do_read("drain_order");
        total++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            bad++;
            $display("FAIL drain_empty: got empty=%0b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_full_rw();
        logic signed [15:0] e;
        do_reset();
        for (int k = 20; k < 36; k++) begin
            send_group(k, k, k, k, 1'b1);
            tick();
        end
        send_group(50, 50, 50, 50, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        e = 16'(exp_q.pop_front());
        exp_q.push_back(50);
        total++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_valid !== 1'b1 || rd_data !== e) begin
            bad++;
            $display("FAIL full_rw: got count=%0d ovf=%0b valid=%0b data=%0d, want 16 0 1 %0d",
                     count, overflow, rd_valid, rd_data, e);
        end
        for (int k = 0; k < 16; k++) do_read("full_rw_drain");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 16'sd50 || count !== 5'd0) begin
            bad++;
            $display("FAIL empty_read: got valid=%0b data=%0d count=%0d, want 0 50 0",
                     rd_valid, rd_data, count);
        end
        send_group(77, 77, 77, 77, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        exp_q.push_back(77);
        total++;
        if (count !== 5'd1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_rw: got count=%0d valid=%0b, want 1 0", count, rd_valid);
        end
        do_read("empty_rw_data");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_group(123, 123, 123, 123, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_sample = 16'sd5000;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        tick();
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        exp_q.delete();
        send_group(1000, 1000, 1000, 1000, 1'b1);
        tick();
        total++;
        if (count !== 5'd1) begin
            bad++;
            $display("FAIL reset_no_stale: got count=%0d, want 1", count);
        end
        do_read("reset_fresh_1000");
    endtask

    task automatic test_flags_clr();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send_group(500, 500, 500, 500, 1'b1);
            tick();
        end
        total++;
        if (overflow !== 1'b1 || peak !== 15'd500) begin
            bad++;
            $display("FAIL flags_set: got ovf=%0b peak=%0d, want 1 500", overflow, peak);
        end
        send_group(300, 300, 300, 300, 1'b1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        total++;
        if (overflow !== 1'b0 || peak !== 15'd300) begin
            bad++;
            $display("FAIL flags_clr_write: got ovf=%0b peak=%0d, want 0 300", overflow, peak);
        end
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        total++;
        if (peak !== 15'd0) begin
            bad++;
            $display("FAIL flags_clr_idle: got peak=%0d, want 0", peak);
        end
        for (int k = 0; k < 16; k++) do_read("flags_drain");
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_group(1, 2, 3, 4, 1'b1);
        send_group(-8, -8, -8, -9, 1'b1);
        send_group(7, 7, 7, 7, 1'b1);
        tick();
        total++;
        if (count !== 5'd3) begin
            bad++;
            $display("FAIL b2b_count: got count=%0d, want 3", count);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic signed [15:0] e;
            tick();
            e = 16'(exp_q.pop_front());
            total++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                bad++;
                $display("FAIL b2b_read: got valid=%0b data=%0d, want 1 %0d", rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_empty: got empty=%0b, want 1", empty);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mean();
        test_floor();
        test_full_overflow();
        test_full_rw();
        test_reset_mid();
        test_flags_clr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
